// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencing with
// Moore-style strobes, sticky illegal-opcode flag and a wrapping retired-instruction counter.
module multicycle_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [5:0]       opcode_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic [1:0]       pc_src_o,
   output logic             ir_write_o,
   output logic             iord_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             alu_src_o,
   output logic [1:0]       alu_op_o,
   output logic             reg_dst_o,
   output logic             mem_to_reg_o,
   output logic             reg_write_o,
   output logic             busy_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] retired_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic             stop_q, stop_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             complete;
   logic             stop_seen;

   function automatic logic needs_exec(input logic [5:0] op);
      return (op == OP_R) || (op == OP_ORI) || (op == OP_ADDI) ||
             (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

   // Stop requests only count once the instruction has left FETCH.
   assign stop_seen = stop_q | stop_i;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      stop_d    = stop_q;
      illegal_d = illegal_q;
      retired_d = retired_q;
      complete  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready_i) state_d = S_DECODE;
         end
         S_DECODE: begin
            op_d   = opcode_i;
            stop_d = stop_seen;
            if (opcode_i == OP_J) begin
               complete = 1'b1;
            end else if (needs_exec(opcode_i)) begin
               state_d = S_EXEC;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_EXEC: begin
            stop_d = stop_seen;
            case (op_q)
               OP_R, OP_ORI, OP_ADDI: state_d = S_WB;
               OP_LW, OP_SW:          state_d = S_MEM;
               OP_BEQ:                complete = 1'b1;
               default:               state_d = S_IDLE;
            endcase
         end
         S_MEM: begin
            stop_d = stop_seen;
            if (mem_ready_i) begin
               if (op_q == OP_LW) state_d = S_WB;
               else               complete = 1'b1;
            end
         end
         S_WB: begin
            stop_d   = stop_seen;
            complete = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (complete) begin
         retired_d = retired_q + CNT_W'(1);
         state_d   = stop_seen ? S_IDLE : S_FETCH;
      end
      if (state_d == S_IDLE) stop_d = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         stop_q    <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         stop_q    <= stop_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   // Strobes decode from registered state; only mem_ready_i/zero_i qualify them.
   always_comb begin
      pc_write_o   = 1'b0;
      pc_src_o     = 2'b00;
      ir_write_o   = 1'b0;
      iord_o       = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      alu_src_o    = 1'b0;
      alu_op_o     = 2'b00;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_o = 1'b1;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
            end
         end
         S_DECODE: begin
            if (opcode_i == OP_J) begin
               pc_write_o = 1'b1;
               pc_src_o   = 2'b10;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_R:   alu_op_o = 2'b10;
               OP_ORI: begin
                  alu_op_o  = 2'b11;
                  alu_src_o = 1'b1;
               end
               OP_ADDI, OP_LW, OP_SW: alu_src_o = 1'b1;
               OP_BEQ: begin
                  alu_op_o   = 2'b01;
                  pc_src_o   = 2'b01;
                  pc_write_o = zero_i;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            iord_o      = 1'b1;
            mem_read_o  = (op_q == OP_LW);
            mem_write_o = (op_q == OP_SW);
         end
         S_WB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = (op_q == OP_R);
            mem_to_reg_o = (op_q == OP_LW);
         end
         default: ;
      endcase
   end

   assign busy_o    = (state_q != S_IDLE);
   assign illegal_o = illegal_q;
   assign retired_o = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 clk_i  in  1  single clock; all state changes on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 start_i  in  1  begin execution from IDLE.
REQ-005 stop_i  in  1  request halt after the current instruction.
REQ-006 opcode_i  in  6  instruction bits [31:26] from instruction register.
REQ-007 zero_i  in  1  ALU zero flag.
REQ-008 mem_ready_i  in  1  memory access completes this cycle.
REQ-009 pc_write_o  out  1  PC load strobe.
REQ-010 pc_src_o  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target.
REQ-011 ir_write_o  out  1  instruction register load strobe.
REQ-012 iord_o  out  1  memory address select: 0 PC, 1 ALU result.
REQ-013 mem_read_o  out  1  memory read request.
REQ-014 mem_write_o  out  1  memory write request.
REQ-015 alu_src_o  out  1  ALU B operand: 0 register, 1 immediate.
REQ-016 alu_op_o  out  2  00 add, 01 sub, 10 funct-decoded, 11 or.
REQ-017 reg_dst_o  out  1  destination: 0 rt, 1 rd.
REQ-018 mem_to_reg_o  out  1  write-back source: 0 ALU, 1 memory.
REQ-019 reg_write_o  out  1  register file write strobe.
REQ-020 busy_o  out  1  high in every state except IDLE.
REQ-021 illegal_o  out  1  sticky: unsupported opcode decoded.
REQ-022 retired_o  out  CNT_W  count of completed instructions.

Function
REQ-023 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB; all outputs not named active in a state SHALL be 0 (Moore-style, plus listed zero_i/mem_ready_i qualifiers).
REQ-024 IDLE: start_i=1 -> FETCH next cycle; start_i while not IDLE ignored.
REQ-025 FETCH: mem_read_o=1, iord_o=0; stay while mem_ready_i=0; cycle with mem_ready_i=1 asserts ir_write_o=1, pc_write_o=1, pc_src_o=00, -> DECODE.
REQ-026 DECODE: opcode_i SHALL be latched internally; later opcode_i changes have no effect on the instruction.
REQ-027 DECODE transitions: 000010 (j) asserts pc_write_o=1, pc_src_o=10, completes; 000000, 001101, 001000, 100011, 101011, 000100 -> EXEC; any other opcode sets illegal_o=1 -> IDLE without retiring.
REQ-028 EXEC: R alu_op_o=10; ori 11, alu_src_o=1; addi/lw/sw 00, alu_src_o=1; beq 01, alu_src_o=0.
REQ-029 EXEC next: R/ori/addi -> WB; lw/sw -> MEM; beq asserts pc_write_o=zero_i, pc_src_o=01, completes.
REQ-030 MEM: iord_o=1; lw mem_read_o=1, sw mem_write_o=1; hold until mem_ready_i=1; then lw -> WB, sw completes.
REQ-031 WB: reg_write_o=1; reg_dst_o=1 for R only; mem_to_reg_o=1 for lw only; completes.
REQ-032 "Completes": retired_o increments by 1 (wraps all-ones -> 0), next state FETCH, or IDLE if stop_i was sampled high in any cycle since leaving FETCH for this instruction (pending-stop flag, cleared on entry to IDLE).
REQ-033 Latency (mem_ready_i immediate): j 2, beq 3, sw 4, R/ori/addi 4, lw 5 cycles FETCH-to-FETCH.
REQ-034 illegal_o SHALL remain 1 until reset; start_i after illegal SHALL restart fetch normally.

Reset
REQ-035 rst_i=1 SHALL immediately force IDLE, clear retired_o, illegal_o, pending-stop, latched opcode, and drive all outputs 0, including mid-MEM-wait; first active edge after release evaluates IDLE.

Verification
REQ-036 Reset, start_i pulse, mem_ready_i=1, opcode 000000 -> FETCH,DECODE,EXEC(alu_op 10),WB(reg_write 1, reg_dst 1), retired_o=1.
REQ-037 lw 100011, mem_ready_i low 3 cycles in MEM -> mem_read_o,iord_o held 4 cycles, then WB with mem_to_reg_o=1; sw 101011 -> mem_write_o, no WB.
REQ-038 beq with zero_i=1 -> pc_write_o=1, pc_src_o=01 in EXEC; zero_i=0 -> pc_write_o=0; both retire.
REQ-039 Opcode 111111 -> illegal_o=1, IDLE, retired_o unchanged; rst_i clears illegal_o.
REQ-040 stop_i pulse in EXEC of addi -> WB completes, IDLE, busy_o=0; retired_o from 16'hFFFF wraps to 0.
REQ-041 rst_i asserted mid-MEM wait -> outputs 0 asynchronously, IDLE, no write strobe issued.
